// File: rtl/reset_issuer_pkg.sv
// Shared definitions for the reset pulse issuer.
// Holds the issuer FSM state encoding, the width of the completed-pulse
// counter, and the helper that turns a requested length into the length
// that is actually driven. It has no ports.
package reset_issuer_pkg;

   localparam int RST_COUNT_WIDTH = 16;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ASSERT  = 2'd1,
      HOLDOFF = 2'd2
   } issuerState_t;

   // A request shorter than the minimum is stretched to the minimum. A
   // request of 0 is also stretched, because the minimum is at least 1.
   function automatic int unsigned eff_len(input int unsigned reqLen,
                                           input int unsigned minAssert);
      if (reqLen < minAssert) begin
         return minAssert;
      end
      return reqLen;
   endfunction

endpackage

// File: rtl/rst_down_counter.sv
// Loadable down-counter that times both the asserted phase and the
// de-assert holdoff of the reset pulse issuer.
// Ports:
//   CLK        rising-edge clock
//   RST        asynchronous active-high reset, loads RESET_VALUE
//   load       load load_value on the next edge (has priority over dec)
//   load_value value to load
//   dec        decrement on the next edge, holding at zero
//   count      current count
//   is_zero    count equals zero
module rst_down_counter #(
   parameter int                   CNT_WIDTH   = 8,
   parameter logic [CNT_WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 load,
   input  logic [CNT_WIDTH-1:0] load_value,
   input  logic                 dec,
   output logic [CNT_WIDTH-1:0] count,
   output logic                 is_zero
);

   logic [CNT_WIDTH-1:0] countQ;
   logic [CNT_WIDTH-1:0] countD;

   // Next count. A load wins over a decrement. The count holds at zero so a
   // stray decrement can never wrap it around to the maximum value.
   always_comb begin
      countD = countQ;
      if (load) begin
         countD = load_value;
      end else if (dec && (countQ != '0)) begin
         countD = countQ - CNT_WIDTH'(1);
      end
   end

   // The reset value is set by the parent, so the power-on pulse is already
   // timed while reset is still asserted.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         countQ <= RESET_VALUE;
      end else begin
         countQ <= countD;
      end
   end

   assign count   = countQ;
   assign is_zero = (countQ == '0);

endmodule

// File: rtl/reset_pulse_issuer.sv
// Issuing end of the reset path. It drives a clock-aligned active-low
// reset pulse of the requested length on OUT_RST_N, then holds off new
// requests for DEASSERT_GAP cycles. It counts completed requested pulses,
// and it issues a power-on pulse of MIN_ASSERT cycles when its own reset
// is released.
// Ports:
//   CLK        rising-edge clock
//   RST        asynchronous active-high reset
//   REQ_VALID  pulse request valid
//   REQ_LEN    requested low time in cycles (0 selects MIN_ASSERT)
//   REQ_READY  high only while idle
//   OUT_RST_N  issued reset, active low, straight from a flop
//   BUSY       high whenever not idle
//   DONE       one-cycle pulse in the first cycle OUT_RST_N is high again
//   RST_COUNT  completed requested pulses, saturating
module reset_pulse_issuer
   import reset_issuer_pkg::*;
#(
   parameter int          CNT_WIDTH    = 8,
   parameter int unsigned MIN_ASSERT   = 2,
   parameter int unsigned DEASSERT_GAP = 4
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic                       REQ_VALID,
   input  logic [CNT_WIDTH-1:0]       REQ_LEN,
   output logic                       REQ_READY,
   output logic                       OUT_RST_N,
   output logic                       BUSY,
   output logic                       DONE,
   output logic [RST_COUNT_WIDTH-1:0] RST_COUNT
);

   localparam logic [CNT_WIDTH-1:0] POWER_ON_LOAD = CNT_WIDTH'(MIN_ASSERT - 1);
   localparam logic [CNT_WIDTH-1:0] GAP_LOAD      =
      (DEASSERT_GAP == 0) ? '0 : CNT_WIDTH'(DEASSERT_GAP - 1);

   issuerState_t               stateQ, stateD;
   logic                       outRstNQ, outRstND;
   logic                       doneQ, doneD;
   logic                       fromReqQ, fromReqD;
   logic [RST_COUNT_WIDTH-1:0] rstCountQ, rstCountD;

   logic                 cntLoad;
   logic [CNT_WIDTH-1:0] cntLoadValue;
   logic                 cntDec;
   logic [CNT_WIDTH-1:0] cntValue;
   logic                 cntZero;
   logic [CNT_WIDTH-1:0] effLen;

   assign effLen = CNT_WIDTH'(eff_len(32'(REQ_LEN), MIN_ASSERT));

   rst_down_counter #(
      .CNT_WIDTH  (CNT_WIDTH),
      .RESET_VALUE(POWER_ON_LOAD)
   ) u_counter (
      .CLK       (CLK),
      .RST       (RST),
      .load      (cntLoad),
      .load_value(cntLoadValue),
      .dec       (cntDec),
      .count     (cntValue),
      .is_zero   (cntZero)
   );

   // Next-state and next-output logic. The counter is loaded with length-1
   // on entry to each timed phase, so a phase lasts exactly `length` edges.
   // The phase ends on the edge where the counter is already zero. Only
   // pulses that came from a request are counted, so the power-on pulse
   // leaves RST_COUNT at zero.
   always_comb begin
      stateD       = stateQ;
      outRstND     = outRstNQ;
      doneD        = 1'b0;
      fromReqD     = fromReqQ;
      rstCountD    = rstCountQ;
      cntLoad      = 1'b0;
      cntLoadValue = '0;
      cntDec       = 1'b0;
      unique case (stateQ)
         IDLE: begin
            if (REQ_VALID) begin
               stateD       = ASSERT;
               outRstND     = 1'b0;
               fromReqD     = 1'b1;
               cntLoad      = 1'b1;
               cntLoadValue = effLen - CNT_WIDTH'(1);
            end
         end
         ASSERT: begin
            if (!cntZero) begin
               cntDec = (cntValue != '0);
            end else begin
               outRstND = 1'b1;
               doneD    = 1'b1;
               if (fromReqQ && (rstCountQ != '1)) begin
                  rstCountD = rstCountQ + RST_COUNT_WIDTH'(1);
               end
               if (DEASSERT_GAP == 0) begin
                  stateD = IDLE;
               end else begin
                  stateD       = HOLDOFF;
                  cntLoad      = 1'b1;
                  cntLoadValue = GAP_LOAD;
               end
            end
         end
         HOLDOFF: begin
            if (!cntZero) begin
               cntDec = (cntValue != '0);
            end else begin
               stateD = IDLE;
            end
         end
         default: begin
            stateD = IDLE;
         end
      endcase
   end

   // State and output flops. Reset places the issuer directly in the
   // asserted phase with OUT_RST_N low. This makes releasing reset start
   // the power-on pulse without any extra logic.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         stateQ    <= ASSERT;
         outRstNQ  <= 1'b0;
         doneQ     <= 1'b0;
         fromReqQ  <= 1'b0;
         rstCountQ <= '0;
      end else begin
         stateQ    <= stateD;
         outRstNQ  <= outRstND;
         doneQ     <= doneD;
         fromReqQ  <= fromReqD;
         rstCountQ <= rstCountD;
      end
   end

   // Every output is either a flop or a decode of the state register, so no
   // input reaches an output combinationally.
   assign REQ_READY = (stateQ == IDLE);
   assign BUSY      = (stateQ != IDLE);
   assign OUT_RST_N = outRstNQ;
   assign DONE      = doneQ;
   assign RST_COUNT = rstCountQ;

endmodule
